// File: rtl/int_arbiter_pkg.sv
// Shared definitions for the platform interrupt arbiter: register offsets,
// ID encoding and the per-source gateway state type.
package int_arbiter_pkg;

  localparam int ID_W = 8;

  localparam logic [7:0] ADDR_PENDING   = 8'h00;
  localparam logic [7:0] ADDR_ENABLE    = 8'h04;
  localparam logic [7:0] ADDR_THRESHOLD = 8'h08;
  localparam logic [7:0] ADDR_CLAIM     = 8'h0C;
  localparam logic [7:0] ADDR_PRIO_BASE = 8'h20;

  localparam logic [ID_W-1:0] INT_NONE = '0;

  typedef enum logic {
    GW_IDLE       = 1'b0,
    GW_IN_SERVICE = 1'b1
  } gw_state_e;

endpackage

// File: rtl/int_gateway.sv
// Per-source interrupt gateway: a pending latch plus an IDLE/IN_SERVICE
// state machine, so a level source is presented once per claim/complete.
module int_gateway
  import int_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      irq_i,
  input  logic      claim_i,
  input  logic      complete_i,
  output logic      pending_o,
  output gw_state_e state_o
);

  gw_state_e state_q, state_d;
  logic      pending_q, pending_d;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (claim_i) begin
      pending_d = 1'b0;
      state_d   = GW_IN_SERVICE;
    end else begin
      // The source stays masked while in service; a still-high level re-pends
      // only on the edge after complete.
      if (irq_i && !pending_q && (state_q == GW_IDLE)) pending_d = 1'b1;
      if (complete_i && (state_q == GW_IN_SERVICE)) state_d = GW_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= GW_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
  assign state_o   = state_q;

endmodule

// File: rtl/int_arbiter.sv
// Platform interrupt arbiter: gateways per source, max-priority selection with
// lowest-index tie-break, and a memory-mapped claim/complete register port.
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [7:0]       addr_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  output logic [7:0]       int_flag_o
);

  // Bus handshake: a single-cycle strobe (we_i or re_i) qualifies addr_i/data_i
  // at the rising edge; data_o is always valid combinationally for addr_i.

  logic [N_SRC-1:0]  pending;
  gw_state_e         gw_state [N_SRC];
  logic [N_SRC-1:0]  claim_vec, complete_vec, eligible;
  logic [N_SRC-1:0]  enable_q, enable_d;
  logic [PRIO_W-1:0] thr_q, thr_d;
  logic [PRIO_W-1:0] prio_q [N_SRC];
  logic [PRIO_W-1:0] prio_d [N_SRC];
  logic [ID_W-1:0]   best_id_q, best_id_d;
  logic [PRIO_W-1:0] best_prio;
  logic [7:0]        prio_off;
  logic [5:0]        prio_idx;
  logic              prio_hit, claim_sel;
  logic              unused_data;

  assign unused_data = ^data_i[31:ID_W];
  assign prio_off    = addr_i - ADDR_PRIO_BASE;
  assign prio_idx    = prio_off[7:2];
  assign prio_hit    = (addr_i >= ADDR_PRIO_BASE) && (prio_off[1:0] == 2'b00);
  assign claim_sel   = (addr_i == ADDR_CLAIM);

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    assign claim_vec[k]    = re_i && claim_sel && (best_id_q == ID_W'(k + 1));
    assign complete_vec[k] = we_i && claim_sel && (data_i[ID_W-1:0] == ID_W'(k + 1))
                             && (gw_state[k] == GW_IN_SERVICE);
    // A source claimed this cycle is excluded so it is never offered twice.
    assign eligible[k] = pending[k] && enable_q[k] && !claim_vec[k] && (prio_q[k] > thr_q);

    int_gateway u_gw (
      .clk        (clk),
      .rst        (rst),
      .irq_i      (irq_i[k]),
      .claim_i    (claim_vec[k]),
      .complete_i (complete_vec[k]),
      .pending_o  (pending[k]),
      .state_o    (gw_state[k])
    );
  end

  always_comb begin
    best_id_d = INT_NONE;
    best_prio = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (eligible[k] && (prio_q[k] > best_prio)) begin
        best_prio = prio_q[k];
        best_id_d = ID_W'(k + 1);
      end
    end
  end

  always_comb begin
    enable_d = enable_q;
    thr_d    = thr_q;
    prio_d   = prio_q;
    if (we_i) begin
      if (addr_i == ADDR_ENABLE) enable_d = data_i[N_SRC-1:0];
      if (addr_i == ADDR_THRESHOLD) thr_d = data_i[PRIO_W-1:0];
      for (int k = 0; k < N_SRC; k++) begin
        if (prio_hit && (prio_idx == 6'(k))) prio_d[k] = data_i[PRIO_W-1:0];
      end
    end
  end

  always_comb begin
    data_o = '0;
    case (addr_i)
      ADDR_PENDING:   data_o[N_SRC-1:0]  = pending;
      ADDR_ENABLE:    data_o[N_SRC-1:0]  = enable_q;
      ADDR_THRESHOLD: data_o[PRIO_W-1:0] = thr_q;
      ADDR_CLAIM:     data_o[ID_W-1:0]   = best_id_q;
      default: begin
        for (int k = 0; k < N_SRC; k++) begin
          if (prio_hit && (prio_idx == 6'(k))) data_o[PRIO_W-1:0] = prio_q[k];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q  <= '0;
      thr_q     <= '0;
      best_id_q <= INT_NONE;
      for (int k = 0; k < N_SRC; k++) prio_q[k] <= '0;
    end else begin
      enable_q  <= enable_d;
      thr_q     <= thr_d;
      best_id_q <= best_id_d;
      for (int k = 0; k < N_SRC; k++) prio_q[k] <= prio_d[k];
    end
  end

  assign int_flag_o = best_id_q;

endmodule
